// File: rtl/bram_access_pkg.sv
// Shared state encoding and counter sizing for the BRAM access responder.
// Pure type/constant package: no latency, no backpressure.
package bram_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATENCY,
        ST_WRITE,
        ST_READ,
        ST_REFRESH,
        ST_RELEASE
    } state_e;

    localparam int MAX_BEATS    = 1024;
    localparam int BEAT_CNT_W   = $clog2(MAX_BEATS) + 1;
    localparam int LAT_CNT_W    = 4;
    localparam int ACCESS_NUM_W = 10;

    // A zero beat count on the bus means a single beat.
    function automatic logic [BEAT_CNT_W-1:0] beats_from_num(input logic [ACCESS_NUM_W-1:0] num);
        return (num == '0) ? BEAT_CNT_W'(1) : BEAT_CNT_W'(num);
    endfunction

endpackage

// File: rtl/bram_access_responder_store.sv
// Single-port 16-bit word RAM with per-byte write enables and a registered read port.
// Read data appears one cycle after rd_en_i and holds otherwise; never stalls.
module bram_word_store
    import bram_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  rd_en_i,
    input  logic                  wr_lo_i,
    input  logic                  wr_hi_i,
    input  logic [15:0]           wdata_i,
    output logic [15:0]           rdata_o
);

    logic [15:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [15:0] rdata_q;

    // Array is deliberately left without reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_lo_i) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (wr_hi_i) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        rdata_q <= '0;
        else if (rd_en_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_access_responder.sv
// Request/flag/idle memory responder backed by block RAM with optional refresh stalls.
// First beat ACCESS_LATENCY cycles after acceptance; held requests park in RELEASE until dropped.
module bram_access_responder
    import bram_access_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int ACCESS_LATENCY   = 3,
    parameter int REFRESH_INTERVAL = 0,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [24:0] address,
    input  logic [9:0]  access_num,
    input  logic [15:0] data_in,
    input  logic        ldqm,
    input  logic        udqm,
    input  logic        write_request,
    input  logic        read_request,
    output logic [15:0] data_out,
    output logic        write_flag,
    output logic        read_flag,
    output logic        idle
);

    localparam logic [LAT_CNT_W-1:0] LAT_PRELOAD =
        LAT_CNT_W'((ACCESS_LATENCY > 1) ? ACCESS_LATENCY - 2 : 0);
    localparam logic [LAT_CNT_W-1:0] REF_PRELOAD = LAT_CNT_W'(REFRESH_CYCLES - 1);
    localparam int                   REF_W       = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [REF_W-1:0]     REF_LAST    =
        REF_W'((REFRESH_INTERVAL > 0) ? REFRESH_INTERVAL - 1 : 0);

    state_e                  state_q, state_d;
    logic                    dir_wr_q, dir_wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BEAT_CNT_W-1:0]   beats_q, beats_d;
    logic [LAT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
    logic                    ref_pend_q, ref_pend_d;
    logic                    wflag_q, rflag_q, idle_q;

    logic                    ref_expire;
    logic                    ram_rd, ram_wr;
    logic [ADDR_WIDTH-1:0]   cur_addr;

    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_expire = 1'b0;
        if (REFRESH_INTERVAL > 0) begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d  = '0;
                ref_expire = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end
    end

    // In IDLE the RAM sees the bus address directly so a latency of 1 can still
    // prefetch the first read word on the acceptance edge.
    always_comb begin
        state_d    = state_q;
        dir_wr_d   = dir_wr_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        ref_pend_d = ref_pend_q;
        cur_addr   = (state_q == ST_IDLE) ? address[ADDR_WIDTH-1:0] : addr_q;

        case (state_q)
            ST_IDLE: begin
                if (ref_pend_q) begin
                    state_d = ST_REFRESH;
                    cnt_d   = REF_PRELOAD;
                end else if (write_request || read_request) begin
                    dir_wr_d = write_request;
                    addr_d   = address[ADDR_WIDTH-1:0];
                    beats_d  = beats_from_num(access_num);
                    cnt_d    = LAT_PRELOAD;
                    if (ACCESS_LATENCY > 1) state_d = ST_LATENCY;
                    else                    state_d = write_request ? ST_WRITE : ST_READ;
                end
            end
            ST_LATENCY: begin
                if (cnt_q == '0) state_d = dir_wr_q ? ST_WRITE : ST_READ;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WRITE, ST_READ: begin
                beats_d = beats_q - 1'b1;
                if (beats_q == BEAT_CNT_W'(1)) state_d = ST_RELEASE;
            end
            ST_REFRESH: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    ref_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!write_request && !read_request) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (ref_expire) ref_pend_d = 1'b1;

        // Reads fetch one word ahead of read_flag; writes land on the beat's own edge.
        ram_wr = (state_q == ST_WRITE);
        ram_rd = (state_d == ST_READ);
        if (ram_wr || ram_rd) addr_d = cur_addr + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_wr_q   <= 1'b0;
            addr_q     <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            wflag_q    <= 1'b0;
            rflag_q    <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            dir_wr_q   <= dir_wr_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            wflag_q    <= (state_d == ST_WRITE);
            rflag_q    <= (state_d == ST_READ);
            idle_q     <= (state_d == ST_IDLE) && !ref_pend_d;
        end
    end

    bram_word_store #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clock   (clock),
        .reset   (reset),
        .addr_i  (cur_addr),
        .rd_en_i (ram_rd),
        .wr_lo_i (ram_wr && !ldqm),
        .wr_hi_i (ram_wr && !udqm),
        .wdata_i (data_in),
        .rdata_o (data_out)
    );

    assign write_flag = wflag_q;
    assign read_flag  = rflag_q;
    assign idle       = idle_q;

    generate
        if (ADDR_WIDTH < 25) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[24:ADDR_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_bram_access_responder.sv
// Bench for bram_access_responder: three instances (16-bit/lat 3, 4-bit/lat 1, 8-bit/lat 2 with refresh)
// driven by a table of single-beat accesses plus burst, wrap, held-request, reset and refresh sequences.
module tb_bram_access_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [24:0] address;
    logic [9:0]  access_num;
    logic [15:0] data_in;
    logic        ldqm, udqm;
    logic        wreq [3];
    logic        rreq [3];
    logic [15:0] dout [3];
    logic        wf [3];
    logic        rf [3];
    logic        idl [3];

    int checks = 0;
    int errors = 0;

    logic [15:0] bdat [16];
    logic        bl   [16];
    logic        bu   [16];
    logic [15:0] bexp [16];

    typedef struct packed {
        logic        wr;
        logic        both;
        logic [24:0] a;
        logic [9:0]  num;
        logic [15:0] wd;
        logic        lm;
        logic        um;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    always #5 clock = ~clock;

    bram_access_responder #(.ADDR_WIDTH(16), .ACCESS_LATENCY(3), .REFRESH_INTERVAL(0), .REFRESH_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .address(address), .access_num(access_num), .data_in(data_in),
        .ldqm(ldqm), .udqm(udqm), .write_request(wreq[0]), .read_request(rreq[0]),
        .data_out(dout[0]), .write_flag(wf[0]), .read_flag(rf[0]), .idle(idl[0]));

    bram_access_responder #(.ADDR_WIDTH(4), .ACCESS_LATENCY(1), .REFRESH_INTERVAL(0), .REFRESH_CYCLES(4)) dut_w (
        .clock(clock), .reset(reset), .address(address), .access_num(access_num), .data_in(data_in),
        .ldqm(ldqm), .udqm(udqm), .write_request(wreq[1]), .read_request(rreq[1]),
        .data_out(dout[1]), .write_flag(wf[1]), .read_flag(rf[1]), .idle(idl[1]));

    bram_access_responder #(.ADDR_WIDTH(8), .ACCESS_LATENCY(2), .REFRESH_INTERVAL(10), .REFRESH_CYCLES(4)) dut_r (
        .clock(clock), .reset(reset), .address(address), .access_num(access_num), .data_in(data_in),
        .ldqm(ldqm), .udqm(udqm), .write_request(wreq[2]), .read_request(rreq[2]),
        .data_out(dout[2]), .write_flag(wf[2]), .read_flag(rf[2]), .idle(idl[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic flag_of(input int d, input bit wr);
        return wr ? wf[d] : rf[d];
    endfunction

    task automatic wait_idle(input int d);
        int n = 0;
        while (idl[d] !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("wait idle dut%0d", d), idl[d], 1);
    endtask

    // Called at a negedge; returns at a negedge with the request dropped.
    task automatic run_burst(input string nm, input int d, input bit wr, input bit both,
                             input logic [24:0] a, input logic [9:0] num, input int nb,
                             input int lat, input int idle_wait, input bit nowait);
        int c;
        if (!nowait) wait_idle(d);
        address    = a;
        access_num = num;
        wreq[d]    = wr | both;
        rreq[d]    = !wr | both;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (flag_of(d, wr) !== 1'b1 && c < 40);
        check({nm, " latency"}, c, lat);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) @(negedge clock);
            data_in = bdat[i];
            ldqm    = bl[i];
            udqm    = bu[i];
            check($sformatf("%s beat%0d flag", nm, i), flag_of(d, wr), 1);
            if (both) check($sformatf("%s beat%0d no read", nm, i), rf[d], 0);
            if (!wr)  check($sformatf("%s beat%0d data", nm, i), dout[d], bexp[i]);
        end
        @(negedge clock);
        check({nm, " end flag"}, flag_of(d, wr), 0);
        if (!wr) check({nm, " data hold"}, dout[d], bexp[nb-1]);
        wreq[d] = 1'b0;
        rreq[d] = 1'b0;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (idl[d] !== 1'b1 && c < 20);
        check({nm, " idle return"}, c, idle_wait);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c, nwf, nidle;

        // wr, both, addr, num, wdata, ldqm, udqm, expected read
        tbl[0]  = '{1'b1, 1'b0, 25'h00010,   10'd1, 16'hA55A, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 25'h00010,   10'd1, 16'h0000, 1'b0, 1'b0, 16'hA55A};
        tbl[2]  = '{1'b1, 1'b0, 25'h00020,   10'd1, 16'h1234, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 25'h00020,   10'd1, 16'hABCD, 1'b1, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b0, 25'h00020,   10'd1, 16'h0000, 1'b0, 1'b0, 16'hAB34};
        tbl[5]  = '{1'b1, 1'b0, 25'h00020,   10'd1, 16'h5678, 1'b0, 1'b1, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 25'h00020,   10'd1, 16'h0000, 1'b0, 1'b0, 16'hAB78};
        tbl[7]  = '{1'b1, 1'b0, 25'h00020,   10'd1, 16'hFFFF, 1'b1, 1'b1, 16'h0000};
        tbl[8]  = '{1'b0, 1'b0, 25'h00020,   10'd1, 16'h0000, 1'b0, 1'b0, 16'hAB78};
        tbl[9]  = '{1'b1, 1'b0, 25'h10030,   10'd1, 16'hC0DE, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 1'b0, 25'h00030,   10'd1, 16'h0000, 1'b0, 1'b0, 16'hC0DE};
        tbl[11] = '{1'b1, 1'b0, 25'h00040,   10'd0, 16'h7777, 1'b0, 1'b0, 16'h0000};
        tbl[12] = '{1'b0, 1'b0, 25'h00040,   10'd0, 16'h0000, 1'b0, 1'b0, 16'h7777};
        tbl[13] = '{1'b1, 1'b1, 25'h00050,   10'd1, 16'h4321, 1'b0, 1'b0, 16'h0000};
        tbl[14] = '{1'b0, 1'b0, 25'h00050,   10'd1, 16'h0000, 1'b0, 1'b0, 16'h4321};
        tbl[15] = '{1'b1, 1'b0, 25'h0FFFF,   10'd1, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        tbl[16] = '{1'b0, 1'b0, 25'h1FFFF,   10'd1, 16'h0000, 1'b0, 1'b0, 16'hBEEF};

        reset = 1'b1;
        address = '0; access_num = '0; data_in = '0; ldqm = 1'b0; udqm = 1'b0;
        for (int d = 0; d < 3; d++) begin
            wreq[d] = 1'b0;
            rreq[d] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            bl[i] = 1'b0;
            bu[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("reset data_out", dout[0], 0);
        check("reset write_flag", wf[0], 0);
        check("reset read_flag", rf[0], 0);
        check("reset idle", idl[0], 1);
        check("reset idle refresh dut", idl[2], 1);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            bdat[0] = tbl[i].wd;
            bl[0]   = tbl[i].lm;
            bu[0]   = tbl[i].um;
            bexp[0] = tbl[i].exp;
            run_burst($sformatf("vec%0d", i), 0, tbl[i].wr, tbl[i].both, tbl[i].a, tbl[i].num, 1, 3, 1, 1'b0);
        end
        bl[0] = 1'b0;
        bu[0] = 1'b0;

        // Wrapping burst on the 16-word instance with single-cycle latency.
        for (int i = 0; i < 4; i++) begin
            bdat[i] = 16'h1111 * 16'(i + 1);
            bexp[i] = bdat[i];
        end
        run_burst("wrap wr", 1, 1'b1, 1'b0, 25'h0E, 10'd4, 4, 1, 1, 1'b0);
        run_burst("wrap rd", 1, 1'b0, 1'b0, 25'h0E, 10'd4, 4, 1, 1, 1'b0);
        bexp[0] = 16'h3333;
        bexp[1] = 16'h4444;
        run_burst("wrap rd low", 1, 1'b0, 1'b0, 25'h00, 10'd2, 2, 1, 1, 1'b0);

        // Request held long after its single beat.
        wait_idle(0);
        address = 25'h60; access_num = 10'd1; data_in = 16'h0001; wreq[0] = 1'b1;
        nwf = 0;
        nidle = 0;
        repeat (20) begin
            @(negedge clock);
            nwf   += int'(wf[0]);
            nidle += int'(idl[0]);
        end
        check("held beats", nwf, 1);
        check("held idle low", nidle, 0);
        wreq[0] = 1'b0;
        @(negedge clock);
        check("held idle return", idl[0], 1);
        bexp[0] = 16'h0001;
        run_burst("held rd", 0, 1'b0, 1'b0, 25'h60, 10'd1, 1, 3, 1, 1'b0);

        // Reset on beat 2 of a 5-beat write over a prefilled region.
        for (int i = 0; i < 5; i++) bdat[i] = 16'hA000 + 16'(i);
        run_burst("rst pre", 0, 1'b1, 1'b0, 25'h100, 10'd5, 5, 3, 1, 1'b0);
        for (int i = 0; i < 5; i++) bdat[i] = 16'hB000 + 16'(i);
        wait_idle(0);
        address = 25'h100; access_num = 10'd5; wreq[0] = 1'b1;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (wf[0] !== 1'b1 && c < 40);
        check("rst latency", c, 3);
        data_in = bdat[0];
        @(negedge clock);
        data_in = bdat[1];
        @(negedge clock);
        data_in = bdat[2];
        check("rst beat2 flag", wf[0], 1);
        reset = 1'b1;
        #1;
        check("rst write_flag", wf[0], 0);
        check("rst read_flag", rf[0], 0);
        check("rst idle", idl[0], 1);
        check("rst data_out", dout[0], 0);
        wreq[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        bexp[0] = 16'hB000; bexp[1] = 16'hB001;
        bexp[2] = 16'hA002; bexp[3] = 16'hA003; bexp[4] = 16'hA004;
        run_burst("rst rd", 0, 1'b0, 1'b0, 25'h100, 10'd5, 5, 3, 1, 1'b0);

        // Refresh: request raised on the expiry cycle waits 1 IDLE + 4 REFRESH + 1 IDLE, then latency 2.
        wait_idle(2);
        c = 0;
        while (idl[2] === 1'b1 && c < 30) begin
            @(negedge clock);
            c++;
        end
        check("refresh expiry seen", idl[2], 0);
        bdat[0] = 16'h5A5A;
        run_burst("ref wr", 2, 1'b1, 1'b0, 25'h12, 10'd1, 1, 7, 1, 1'b1);
        // Next expiry lands inside this burst, so idle waits out RELEASE->IDLE, 4 REFRESH, IDLE.
        for (int i = 0; i < 8; i++) begin
            bdat[i] = 16'h0100 * 16'(i + 1) + 16'h00C3;
            bexp[i] = bdat[i];
        end
        run_burst("ref defer wr", 2, 1'b1, 1'b0, 25'h80, 10'd8, 8, 2, 6, 1'b0);
        run_burst("ref defer rd", 2, 1'b0, 1'b0, 25'h80, 10'd8, 8, 2, 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
